// File: rtl/imem_loader.sv
// imem_loader: assembles a framed little-endian byte stream into 32-bit words
// and writes them to instruction memory from word 0. The CPU is held in reset
// until the whole program has been written.
//   clk        system clock
//   rst        synchronous active-low reset
//   in_data    stream byte; in_valid/in_ready handshake, one byte per edge
//   reload     one-cycle request for a new load, honoured only once loading is done
//   imem_we    one-cycle write strobe per word, with imem_addr/imem_wdata
//   cpu_hold   1 keeps the CPU in reset; done = program loaded and CPU released
//   error      frame length was 0 or larger than MAX_WORDS; sticky until reset
module imem_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);
    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

    typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR} state_t;

    state_t                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           asm_q, asm_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [15:0]           count_full;
    logic                  xfer;

    always_comb begin
        in_ready   = (state_q == LEN_LO) || (state_q == LEN_HI) || (state_q == DATA);
        imem_we    = state_q == WRITE;
        done       = state_q == DONE;
        cpu_hold   = state_q != DONE;
        error      = state_q == ERROR;
        imem_addr  = addr_q;
        imem_wdata = wdata_q;
        xfer       = in_valid && in_ready;
        count_full = {in_data, count_q[7:0]};
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        case (state_q)
            LEN_LO: if (xfer) begin
                count_d[7:0] = in_data;
                state_d      = LEN_HI;
            end
            LEN_HI: if (xfer) begin
                count_d[15:8] = in_data;
                state_d       = (count_full == 16'd0 || count_full > MAX_W) ? ERROR : DATA;
                byte_idx_d    = 2'd0;
                word_idx_d    = '0;
            end
            DATA: if (xfer) begin
                // Bytes shift in from the top, so after three bytes the low
                // 24 bits of the word sit in lane order and the fourth byte
                // completes it directly into the output register.
                byte_idx_d = byte_idx_q + 2'd1;
                asm_d      = {in_data, asm_q[23:8]};
                if (byte_idx_q == 2'd3) begin
                    wdata_d = {in_data, asm_q};
                    addr_d  = word_idx_q;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (16'(word_idx_q) == count_q - 16'd1) state_d = DONE;
                else begin
                    word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                    state_d    = DATA;
                end
            end
            DONE: if (reload) begin
                state_d    = LEN_LO;
                word_idx_d = '0;
                byte_idx_d = 2'd0;
                asm_d      = 24'd0;
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= LEN_LO;
            count_q    <= 16'd0;
            word_idx_q <= '0;
            byte_idx_q <= 2'd0;
            asm_q      <= 24'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed stimulus with a byte-count model checked every cycle
module tb_imem_loader;
    localparam int AW   = 8;
    localparam int MAXW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    in_data = 8'd0;
    logic          in_valid = 1'b0;
    logic          reload = 1'b0;
    logic          in_ready, imem_we, cpu_hold, done, error;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Model: counts bytes accepted in the current frame and derives everything from that.
    typedef struct {
        int          nbytes;
        int          cnt;
        bit          err;
        bit          fin;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] word;
    } model_t;

    model_t m = '{default: 0};

    function automatic model_t next_model(input model_t s, input logic r, input logic v,
                                          input logic rl, input logic [7:0] d);
        model_t n;
        int k;
        n = s;
        if (!r) n = '{default: 0};
        else if (s.wr) begin
            n.wr = 1'b0;
            if (int'(s.addr) == s.cnt - 1) n.fin = 1'b1;
        end else if (s.fin) begin
            if (rl) begin
                n.fin    = 1'b0;
                n.nbytes = 0;
                n.word   = 32'd0;
            end
        end else if (!s.err && v) begin
            if (s.nbytes == 0) n.cnt = int'(d);
            else if (s.nbytes == 1) begin
                n.cnt = s.cnt + 256 * int'(d);
                n.err = (n.cnt == 0) || (n.cnt > MAXW);
            end else begin
                k = (s.nbytes - 2) % 4;
                n.word[8*k +: 8] = d;
                if (k == 3) begin
                    n.wr    = 1'b1;
                    n.addr  = 8'((s.nbytes - 2) / 4);
                    n.wdata = n.word;
                end
            end
            n.nbytes = s.nbytes + 1;
        end
        return n;
    endfunction

    always @(posedge clk) m <= next_model(m, rst, in_valid, reload, in_data);

    int          total = 0;
    int          passed = 0;
    int          wr_cnt = 0;
    logic [31:0] cap_mem [0:MAXW-1];
    logic [7:0]  last_addr = 8'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Every cycle step: compare against the model at the falling edge, capture writes.
    task automatic tick();
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(!m.err && !m.fin && !m.wr));
        chk("imem_we", 32'(imem_we), 32'(m.wr));
        chk("imem_addr", 32'(imem_addr), 32'(m.addr));
        chk("imem_wdata", imem_wdata, m.wdata);
        chk("cpu_hold", 32'(cpu_hold), 32'(!m.fin));
        chk("done", 32'(done), 32'(m.fin));
        chk("error", 32'(error), 32'(m.err));
        if (imem_we === 1'b1) begin
            cap_mem[imem_addr] = imem_wdata;
            last_addr = imem_addr;
            wr_cnt++;
        end
    endtask

    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        if (t >= 20) chk("send_timeout", 32'(t), 32'(0));
        tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        reload = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        wr_cnt = 0;
    endtask

    initial begin
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);

        // Single word; trailing byte stays on the bus to show it is not consumed.
        send(8'h01); send(8'h00);
        send_word(32'h00500093);
        chk("we_after_4th_byte", 32'(imem_we), 32'd1);
        chk("we_addr", 32'(imem_addr), 32'd0);
        chk("we_data", imem_wdata, 32'h00500093);
        tick();
        chk("done_after_write", 32'(done), 32'd1);
        chk("hold_after_write", 32'(cpu_hold), 32'd0);
        idle(3);
        chk("one_word_writes", 32'(wr_cnt), 32'd1);

        // Two words, 3-cycle valid gap inside the second word.
        do_reset();
        send(8'h02); send(8'h00);
        send_word(32'h00500093);
        send(8'h13); send(8'h01);
        idle(3);
        send(8'hA0); send(8'h00);
        idle(4);
        chk("two_word_writes", 32'(wr_cnt), 32'd2);
        chk("two_word_w0", cap_mem[0], 32'h00500093);
        chk("two_word_w1", cap_mem[1], 32'h00A00113);
        chk("two_word_last_addr", 32'(last_addr), 32'd1);
        chk("two_word_done", 32'(done), 32'd1);

        // Zero length is illegal; stays in error while data is offered.
        do_reset();
        send(8'h00); send(8'h00);
        in_data = 8'h55;
        repeat (3) tick();
        idle(1);
        chk("cnt0_error", 32'(error), 32'd1);
        chk("cnt0_hold", 32'(cpu_hold), 32'd1);
        chk("cnt0_ready", 32'(in_ready), 32'd0);
        chk("cnt0_writes", 32'(wr_cnt), 32'd0);

        // MAX_WORDS+1 is illegal; reset clears it.
        do_reset();
        send(8'h01); send(8'h01);
        idle(3);
        chk("cnt257_error", 32'(error), 32'd1);
        chk("cnt257_writes", 32'(wr_cnt), 32'd0);
        do_reset();
        chk("err_cleared", 32'(error), 32'd0);

        // Reset mid-word (reload there is ignored), then a fresh frame.
        send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
        in_valid = 1'b0;
        reload = 1'b1;
        tick();
        reload = 1'b0;
        do_reset();
        send(8'h01); send(8'h00);
        send_word(32'h00000013);
        idle(3);
        chk("fresh_writes", 32'(wr_cnt), 32'd1);
        chk("fresh_w0", cap_mem[0], 32'h00000013);

        // Reload from DONE, then a new single-word program.
        reload = 1'b1;
        tick();
        reload = 1'b0;
        chk("reload_hold", 32'(cpu_hold), 32'd1);
        chk("reload_done", 32'(done), 32'd0);
        chk("reload_keeps_wdata", imem_wdata, 32'h00000013);
        send(8'h01); send(8'h00);
        send_word(32'h00100073);
        idle(3);
        chk("reload_w0", cap_mem[0], 32'h00100073);
        chk("reload_done_again", 32'(done), 32'd1);

        // Reset coinciding with reload: reset wins and clears the write outputs.
        rst = 1'b0;
        reload = 1'b1;
        tick();
        reload = 1'b0;
        tick();
        rst = 1'b1;
        chk("rst_vs_reload_wdata", imem_wdata, 32'd0);
        chk("rst_vs_reload_hold", 32'(cpu_hold), 32'd1);

        // Largest legal frame.
        do_reset();
        send(8'h00); send(8'h01);
        for (int i = 0; i < MAXW; i++) send_word(32'hC0DE0000 | 32'(i));
        idle(3);
        chk("max_writes", 32'(wr_cnt), 32'(MAXW));
        chk("max_last_addr", 32'(last_addr), 32'(MAXW - 1));
        chk("max_last_word", cap_mem[MAXW-1], 32'hC0DE00FF);
        chk("max_first_word", cap_mem[0], 32'hC0DE0000);
        chk("max_done", 32'(done), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
